// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : prime_pkg
//  Description: Shared widths, defaults and sweep state encoding for prime_sweep.
//  Revision   : 1.0 - initial release
// ============================================================================
package prime_pkg;

    localparam int NUM_W              = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prime_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : prime_fifo
//  Description: Synchronous FIFO, power-of-2 depth, head shown combinationally.
//  Revision   : 1.0 - initial release
// ============================================================================
module prime_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_aw:0]   r_cnt;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_cnt == c_full);
    assign empty     = (r_cnt == '0);
    assign head      = r_mem[r_rd];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_do_pop) r_rd <= r_rd + 1'b1;
            if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/primenumber.sv
`default_nettype none
// ============================================================================
//  Module     : primenumber
//  Description: Combinational 8-bit primality checker.
//  Revision   : 1.0 - initial release
// ============================================================================
module primenumber (
    input  logic [7:0] number,
    output logic       prime
);

    // sqrt(255) < 16, so trial division by the primes below 16 is exhaustive
    always_comb begin
        prime = (number >= 8'd2);
        if ((number != 8'd2)  && (number % 8'd2  == 8'd0)) prime = 1'b0;
        if ((number != 8'd3)  && (number % 8'd3  == 8'd0)) prime = 1'b0;
        if ((number != 8'd5)  && (number % 8'd5  == 8'd0)) prime = 1'b0;
        if ((number != 8'd7)  && (number % 8'd7  == 8'd0)) prime = 1'b0;
        if ((number != 8'd11) && (number % 8'd11 == 8'd0)) prime = 1'b0;
        if ((number != 8'd13) && (number % 8'd13 == 8'd0)) prime = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/prime_sweep.sv
`default_nettype none
// ============================================================================
//  Module     : prime_sweep
//  Description: Sweeps [lo, hi] through primenumber and streams primes out.
//               PRIME_SWEEP_COUNT_EN enables the prime_count register.
//  Revision   : 1.0 - initial release
// ============================================================================
module prime_sweep
    import prime_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] lo,
    input  logic [NUM_W-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] out_number,
    output logic [7:0]       prime_count
);

    state_t           r_state;
    state_t           w_next;
    logic [NUM_W-1:0] r_cur;
    logic [NUM_W-1:0] r_hi;
    logic             r_empty_done;
    logic             w_prime;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_accept;
    logic [NUM_W-1:0] w_head;

    primenumber u_check (
        .number (r_cur),
        .prime  (w_prime)
    );

    prime_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (NUM_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (out_ready),
        .din     (r_cur),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head)
    );

    assign w_accept   = (r_state == IDLE) && start && (lo <= hi);
    // a full FIFO freezes the scan even if a pop frees a slot this cycle
    assign w_push     = (r_state == SCAN) && !w_full && w_prime;
    assign busy       = (r_state != IDLE);
    assign done       = ((r_state == DRAIN) && w_empty) || r_empty_done;
    assign out_valid  = !w_empty;
    assign out_number = w_empty ? '0 : w_head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SCAN;
            SCAN:    if (!w_full && (r_cur == r_hi)) w_next = DRAIN;
            DRAIN:   if (w_empty) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur        <= '0;
            r_hi         <= '0;
            r_empty_done <= 1'b0;
        end else begin
            r_empty_done <= (r_state == IDLE) && start && (lo > hi);
            if (w_accept) begin
                r_cur <= lo;
                r_hi  <= hi;
            end else if ((r_state == SCAN) && !w_full && (r_cur != r_hi)) begin
                r_cur <= r_cur + 1'b1;
            end
        end
    end

`ifdef PRIME_SWEEP_COUNT_EN
    logic [7:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          r_count <= '0;
        else if (w_accept)                     r_count <= '0;
        else if (w_push && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end

    assign prime_count = r_count;
`else
    assign prime_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prime_sweep.sv
`default_nettype none
// ============================================================================
//  Module     : tb_prime_sweep
//  Description: Self-checking bench for prime_sweep against a trial-division model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_prime_sweep;

    typedef int q_t[$];

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] lo = 8'd0;
    logic [7:0] hi = 8'd0;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [7:0] out_number;
    logic [7:0] prime_count;

    int tests = 0;
    int fails = 0;

    q_t got;
    q_t exp;
    int done_cnt, done_cyc, busy_cyc, busy_after, first_valid_cyc;
    int hold_viol, timeout, stall_cur, stall_num, stall_valid;

    prime_sweep #(.FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_number  (out_number),
        .prime_count (prime_count)
    );

    always #5 clock = ~clock;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic q_t model(input int l, input int h);
        q_t q;
        for (int n = l; n <= h; n++) if (is_prime(n)) q.push_back(n);
        return q;
    endfunction

    function automatic int exp_count(input int n);
`ifdef PRIME_SWEEP_COUNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    // mode 0: always ready, 1: random ready, 2: not ready for the first 40 cycles
    task automatic run(input int l, input int h, input int mode);
        bit         pv;
        bit         pr;
        logic [7:0] pn;
        got.delete();
        done_cnt = 0; done_cyc = -1; busy_cyc = 0; busy_after = 0;
        first_valid_cyc = -1; hold_viol = 0; timeout = 0;
        stall_cur = -1; stall_num = -1; stall_valid = -1;
        pv = 1'b0; pr = 1'b0; pn = 8'd0;
        @(negedge clock);
        lo = 8'(l); hi = 8'(h); start = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = (cyc > 40);
            endcase
            if (pv && !pr && (!out_valid || out_number !== pn)) hold_viol++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) got.push_back(int'(out_number));
            if (mode == 2 && cyc == 40) begin
                stall_cur = int'(dut.r_cur); stall_num = int'(out_number); stall_valid = int'(out_valid);
            end
            if (busy) begin
                if (done_cnt > 0) busy_after++;
                else busy_cyc++;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            pv = out_valid; pr = out_ready; pn = out_number;
            if (done_cnt > 0 && cyc >= done_cyc + 4) break;
            if (cyc == 2999) timeout = 1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if ({busy, done, out_valid, out_number, prime_count} !== 19'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%0b done=%0b valid=%0b num=%0d cnt=%0d, want all 0",
                     busy, done, out_valid, out_number, prime_count);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        run(2, 20, 0);
        exp = model(2, 20);
        tests++;
        if (got.size() != exp.size()) begin
            fails++; $display("FAIL basic_len: got %0d primes, want %0d", got.size(), exp.size());
        end else foreach (exp[i]) if (got[i] != exp[i]) begin
            fails++; $display("FAIL basic_val[%0d]: got %0d, want %0d", i, got[i], exp[i]); break;
        end
        tests++;
        if (int'(prime_count) != exp_count(exp.size())) begin
            fails++; $display("FAIL basic_count: got %0d, want %0d", prime_count, exp_count(exp.size()));
        end
        tests++;
        if (done_cnt != 1 || done_cyc != 20) begin
            fails++; $display("FAIL basic_done: got %0d pulses at cycle %0d, want 1 at 20", done_cnt, done_cyc);
        end
        tests++;
        if (first_valid_cyc != 2) begin
            fails++; $display("FAIL basic_latency: first valid cycle %0d, want 2", first_valid_cyc);
        end
        tests++;
        if (busy_after != 0 || timeout != 0) begin
            fails++; $display("FAIL basic_busy_after: got %0d busy cycles after done (timeout=%0d), want 0", busy_after, timeout);
        end
    endtask

    task automatic test_zero_one();
        run(0, 1, 0);
        tests++;
        if (got.size() != 0 || first_valid_cyc != -1) begin
            fails++; $display("FAIL zero_one_stream: got %0d outputs, first valid %0d, want none", got.size(), first_valid_cyc);
        end
        tests++;
        if (done_cnt != 1 || busy_cyc != 3) begin
            fails++; $display("FAIL zero_one_done: got %0d pulses busy %0d, want 1 pulse busy 3", done_cnt, busy_cyc);
        end
        tests++;
        if (prime_count !== 8'd0) begin
            fails++; $display("FAIL zero_one_count: got %0d, want 0", prime_count);
        end
    endtask

    task automatic test_top();
        run(240, 255, 0);
        exp = model(240, 255);
        tests++;
        if (got.size() != exp.size()) begin
            fails++; $display("FAIL top_len: got %0d primes, want %0d", got.size(), exp.size());
        end else foreach (exp[i]) if (got[i] != exp[i]) begin
            fails++; $display("FAIL top_val[%0d]: got %0d, want %0d", i, got[i], exp[i]); break;
        end
        tests++;
        if (done_cnt != 1 || done_cyc != 17 || busy_after != 0) begin
            fails++; $display("FAIL top_done: got %0d pulses at %0d busy_after %0d, want 1 at 17 busy_after 0",
                              done_cnt, done_cyc, busy_after);
        end
        tests++;
        if (int'(dut.r_cur) != 255) begin
            fails++; $display("FAIL top_nowrap: cur=%0d, want 255", dut.r_cur);
        end
    endtask

    task automatic test_backpressure();
        run(2, 30, 2);
        exp = model(2, 30);
        tests++;
        if (stall_cur != 8 || stall_num != 2 || stall_valid != 1) begin
            fails++; $display("FAIL bp_stall: cur=%0d head=%0d valid=%0d, want cur=8 head=2 valid=1",
                              stall_cur, stall_num, stall_valid);
        end
        tests++;
        if (hold_viol != 0) begin
            fails++; $display("FAIL bp_hold: got %0d unstable held cycles, want 0", hold_viol);
        end
        tests++;
        if (got.size() != exp.size() || got.size() != 10) begin
            fails++; $display("FAIL bp_len: got %0d primes, want %0d", got.size(), exp.size());
        end else foreach (exp[i]) if (got[i] != exp[i]) begin
            fails++; $display("FAIL bp_val[%0d]: got %0d, want %0d", i, got[i], exp[i]); break;
        end
        tests++;
        if (done_cnt != 1 || int'(prime_count) != exp_count(10)) begin
            fails++; $display("FAIL bp_done: got %0d pulses count %0d, want 1 pulse count %0d",
                              done_cnt, prime_count, exp_count(10));
        end
    endtask

    task automatic test_inverted();
        run(10, 5, 0);
        tests++;
        if (done_cnt != 1 || done_cyc != 1) begin
            fails++; $display("FAIL inverted_done: got %0d pulses at %0d, want 1 at 1", done_cnt, done_cyc);
        end
        tests++;
        if (busy_cyc != 0 || busy_after != 0 || got.size() != 0) begin
            fails++; $display("FAIL inverted_idle: busy %0d/%0d outputs %0d, want 0/0/0", busy_cyc, busy_after, got.size());
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        int dones;
        seen = 0; dones = 0;
        @(negedge clock);
        lo = 8'd2; hi = 8'd100; start = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            if (out_valid && out_ready) seen++;
            if (seen < 3) @(negedge clock);
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (seen != 3 || {busy, done, out_valid, out_number, prime_count} !== 19'd0) begin
            fails++; $display("FAIL midreset_async: seen=%0d busy=%0b done=%0b valid=%0b num=%0d cnt=%0d, want seen 3 all 0",
                              seen, busy, done, out_valid, out_number, prime_count);
        end
        repeat (4) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++; $display("FAIL midreset_nodone: got %0d done/busy cycles, want 0", dones);
        end
        run(3, 7, 0);
        tests++;
        if (got.size() != 3 || got[0] != 3 || got[1] != 5 || got[2] != 7 || done_cnt != 1) begin
            fails++; $display("FAIL midreset_restart: got %0d primes (%p) %0d dones, want 3,5,7 and 1", got.size(), got, done_cnt);
        end
    endtask

    task automatic test_random();
        int l;
        int h;
        for (int it = 0; it < 6; it++) begin
            l = int'($urandom % 256);
            h = l + int'($urandom % 40);
            if (h > 255) h = 255;
            run(l, h, 1);
            exp = model(l, h);
            tests++;
            if (got.size() != exp.size()) begin
                fails++; $display("FAIL rand_len[%0d..%0d]: got %0d primes, want %0d", l, h, got.size(), exp.size());
            end else foreach (exp[i]) if (got[i] != exp[i]) begin
                fails++; $display("FAIL rand_val[%0d..%0d][%0d]: got %0d, want %0d", l, h, i, got[i], exp[i]); break;
            end
            tests++;
            if (done_cnt != 1 || hold_viol != 0 || timeout != 0 ||
                int'(prime_count) != exp_count(exp.size())) begin
                fails++; $display("FAIL rand_ctl[%0d..%0d]: dones=%0d holdviol=%0d timeout=%0d cnt=%0d, want 1/0/0/%0d",
                                  l, h, done_cnt, hold_viol, timeout, prime_count, exp_count(exp.size()));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_one();
        test_top();
        test_backpressure();
        test_inverted();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
